// File: rtl/mem_pkg.sv
// mem_pkg: shared types and lane helpers for the memory responder.
//   width_t  - access size encoding (byte/half/word/dword)
//   state_t  - responder FSM states; the read-modify-write states exist only
//              when MEMRESP_BYTE_EN_EN is undefined (no per-byte write enables)
//   byte_mask    - 8-bit lane mask for an access of a given size and offset
//   lane_extract - zero-extended, right-justified lane of a dword
//   lane_merge   - dword with the access lanes replaced by right-justified data
package mem_pkg;

    typedef enum logic [1:0] {
        W_BYTE  = 2'd0,
        W_HALF  = 2'd1,
        W_WORD  = 2'd2,
        W_DWORD = 2'd3
    } width_t;

`ifdef MEMRESP_BYTE_EN_EN
    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR,
        DONE
    } state_t;
`endif

    function automatic logic [7:0] byte_mask(input logic [2:0] offset, input width_t width);
        logic [7:0] base;
        case (width)
            W_BYTE:  base = 8'h01;
            W_HALF:  base = 8'h03;
            W_WORD:  base = 8'h0F;
            default: base = 8'hFF;
        endcase
        // Accesses are aligned, so the shifted mask never spills past lane 7.
        return base << offset;
    endfunction

    function automatic logic [63:0] lane_extract(input logic [63:0] dword,
                                                 input logic [2:0]  offset,
                                                 input width_t      width);
        logic [63:0] shifted;
        logic [63:0] lane;
        shifted = dword >> {offset, 3'b000};
        case (width)
            W_BYTE:  lane = {56'd0, shifted[7:0]};
            W_HALF:  lane = {48'd0, shifted[15:0]};
            W_WORD:  lane = {32'd0, shifted[31:0]};
            default: lane = shifted;
        endcase
        return lane;
    endfunction

    function automatic logic [63:0] lane_merge(input logic [63:0] old_dword,
                                               input logic [63:0] wdata,
                                               input logic [2:0]  offset,
                                               input width_t      width);
        logic [7:0]  mask;
        logic [63:0] shifted;
        logic [63:0] merged;
        mask    = byte_mask(offset, width);
        shifted = wdata << {offset, 3'b000};
        for (int i = 0; i < 8; i++) begin
            merged[i*8 +: 8] = mask[i] ? shifted[i*8 +: 8] : old_dword[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_ram.sv
// mem_ram: single-port synchronous RAM of DEPTH 64-bit dwords, 1-cycle read
// latency (rdata reflects the dword addressed at the previous enabled edge).
// Build option MEMRESP_BYTE_EN_EN adds an 8-bit per-byte write enable port.
//   clk   - clock
//   en    - access enable (read, or write when we=1)
//   we    - write enable
//   addr  - dword index
//   wdata - write data
//   be    - byte write enables (MEMRESP_BYTE_EN_EN only)
//   rdata - read data
module mem_ram #(
    parameter int DEPTH     = 8192,
    parameter     INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [63:0]              wdata,
`ifdef MEMRESP_BYTE_EN_EN
    input  logic [7:0]               be,
`endif
    output logic [63:0]              rdata
);

    logic [63:0] mem [DEPTH];

    // NOTE: the array has no reset branch -- RAM contents survive reset and a
    // reset term here would prevent mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
`ifdef MEMRESP_BYTE_EN_EN
                for (int i = 0; i < 8; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
`else
                mem[addr] <= wdata;
`endif
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the MMU physical bus. Services
// byte/half/word/dword reads and writes against an internal dword RAM, answers
// with a one-cycle ready pulse, and rejects misaligned or out-of-range accesses
// (fault=1 with ready, no RAM access).
// Build option MEMRESP_BYTE_EN_EN: RAM has per-byte write enables, so sub-dword
// writes skip the read-modify-write states (2-cycle instead of 3-cycle latency).
//   clk      - clock
//   reset    - asynchronous active-low reset
//   addr     - physical byte address
//   width    - access size (0 byte, 1 half, 2 word, 3 dword)
//   memcycle - request valid, sampled in IDLE only
//   wr       - 1 = write, 0 = read
//   wdata    - right-justified write data
//   rdata    - right-justified, zero-extended read data (0 after write/fault)
//   ready    - one-cycle completion pulse
//   fault    - access rejected, valid with ready
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH     = 8192,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] addr,
    input  logic [1:0]  width,
    input  logic        memcycle,
    input  logic        wr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        ready,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = AW + 3;   // byte-address bits that land inside the RAM

    state_t          state, next_state;
    logic [BW-1:0]   addr_q;
    width_t          width_q;
    logic [63:0]     wdata_q;
    logic            fault_q;
`ifndef MEMRESP_BYTE_EN_EN
    logic [63:0]     merged_q;
`endif

    width_t          req_width;
    logic            misaligned;
    logic            out_of_range;
    logic            bad_req;
    logic [2:0]      off_q;

    logic            ram_en;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [63:0]     ram_wdata;
    logic [63:0]     ram_rdata;
`ifdef MEMRESP_BYTE_EN_EN
    logic [7:0]      ram_be;
`endif

    assign req_width    = width_t'(width);
    assign out_of_range = |addr[63:BW];
    assign bad_req      = misaligned | out_of_range;
    assign off_q        = addr_q[2:0];

    always_comb begin
        misaligned = 1'b0;
        case (req_width)
            W_HALF:  misaligned = addr[0];
            W_WORD:  misaligned = |addr[1:0];
            W_DWORD: misaligned = |addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // The RAM read is launched from the live bus address while accepting in
    // IDLE so its data is ready one cycle later; afterwards the latched
    // address steers the RAM.
    assign ram_addr = (state == IDLE) ? addr[3 +: AW] : addr_q[BW-1:3];

    // NOTE: non-blocking assignment for all clocked state so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_wdata  = wdata_q;
`ifdef MEMRESP_BYTE_EN_EN
        ram_be     = 8'hFF;
`endif
        case (state)
            IDLE: begin
                if (memcycle) begin
                    if (bad_req) begin
                        next_state = DONE;
                    end else if (!wr) begin
                        next_state = RD;
                        ram_en     = 1'b1;
                    end else if (req_width == W_DWORD) begin
                        next_state = WR;
                    end else begin
`ifdef MEMRESP_BYTE_EN_EN
                        next_state = WR;
`else
                        // Fetch the old dword now; merge happens in RMW_RD.
                        next_state = RMW_RD;
                        ram_en     = 1'b1;
`endif
                    end
                end
            end
            RD: begin
                next_state = DONE;
            end
            WR: begin
                ram_en     = 1'b1;
                ram_we     = 1'b1;
`ifdef MEMRESP_BYTE_EN_EN
                ram_wdata  = wdata_q << {off_q, 3'b000};
                ram_be     = byte_mask(off_q, width_q);
`endif
                next_state = DONE;
            end
`ifndef MEMRESP_BYTE_EN_EN
            RMW_RD: begin
                next_state = RMW_WR;
            end
            RMW_WR: begin
                ram_en     = 1'b1;
                ram_we     = 1'b1;
                ram_wdata  = merged_q;
                next_state = DONE;
            end
`endif
            DONE: begin
                // memcycle is ignored here; a new request is seen in IDLE.
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request latch and result register. rdata only changes on the edge that
    // enters DONE, so it stays stable from one completion to the next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            width_q  <= W_BYTE;
            wdata_q  <= '0;
            fault_q  <= 1'b0;
            rdata    <= '0;
`ifndef MEMRESP_BYTE_EN_EN
            merged_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (memcycle) begin
                        addr_q  <= addr[BW-1:0];
                        width_q <= req_width;
                        wdata_q <= wdata;
                        fault_q <= bad_req;
                        if (bad_req) begin
                            rdata <= '0;
                        end
                    end
                end
                RD: begin
                    rdata <= lane_extract(ram_rdata, off_q, width_q);
                end
                WR: begin
                    rdata <= '0;
                end
`ifndef MEMRESP_BYTE_EN_EN
                RMW_RD: begin
                    merged_q <= lane_merge(ram_rdata, wdata_q, off_q, width_q);
                end
                RMW_WR: begin
                    rdata <= '0;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign ready = (state == DONE);
    assign fault = (state == DONE) && fault_q;

    mem_ram #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
`ifdef MEMRESP_BYTE_EN_EN
        .be    (ram_be),
`endif
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder (DEPTH=8192).
// A byte-array reference model over the low 512 bytes predicts read data,
// fault and latency from the access rules; directed cases cover the dword,
// byte-merge, lane-extract, fault, reset-abort and back-to-back scenarios,
// followed by randomized traffic with post-acceptance bus scrambling.
module tb_mem_responder;

    localparam logic [63:0] LIMIT = 64'h10000;   // DEPTH * 8 bytes
`ifdef MEMRESP_BYTE_EN_EN
    localparam int SUB_WR_LAT = 2;
`else
    localparam int SUB_WR_LAT = 3;
`endif

    logic        clk;
    logic        reset;
    logic [63:0] addr;
    logic [1:0]  width;
    logic        memcycle;
    logic        wr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        ready;
    logic        fault;

    mem_responder #(.DEPTH(8192)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .width    (width),
        .memcycle (memcycle),
        .wr       (wr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem_model [512];
    int          n_vectors     = 0;
    int          n_miscompares = 0;
    logic [63:0] last_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [63:0] a, input int bytes);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < bytes; i++) begin
            v[i*8 +: 8] = mem_model[int'(a) + i];
        end
        return v;
    endfunction

    // One complete request: predict, drive, wait (bounded) for ready, check
    // latency/fault/rdata and the single-cycle pulse, then update the model.
    task automatic do_req(input string tag, input bit is_wr, input logic [1:0] w,
                          input logic [63:0] a, input logic [63:0] d, input bit scramble);
        int          bytes;
        bit          exp_fault;
        int          exp_lat;
        logic [63:0] exp_rd;
        int          cyc;
        bit          seen;
        bytes     = 1 << w;
        exp_fault = ((a & 64'(bytes - 1)) != 0) || (a >= LIMIT);
        exp_rd    = (!exp_fault && !is_wr) ? model_read(a, bytes) : 64'd0;
        if (exp_fault)       exp_lat = 1;
        else if (!is_wr)     exp_lat = 2;
        else if (w == 2'd3)  exp_lat = 2;
        else                 exp_lat = SUB_WR_LAT;

        @(negedge clk);
        addr     = a;
        width    = w;
        wr       = is_wr;
        wdata    = d;
        memcycle = 1'b1;
        cyc      = 0;
        seen     = 1'b0;
        while (!seen && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ready) begin
                seen = 1'b1;
            end else if (scramble) begin
                addr     = {$urandom, $urandom};
                wdata    = {$urandom, $urandom};
                width    = 2'($urandom);
                wr       = 1'($urandom);
                memcycle = 1'($urandom);
            end
        end
        memcycle = 1'b0;
        check({tag, " ready"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " fault"}, 64'(fault), 64'(exp_fault));
        check({tag, " rdata"}, rdata, exp_rd);
        last_rdata = rdata;
        @(posedge clk);
        #1;
        check({tag, " pulse end"}, 64'(ready), 64'd0);
        if (is_wr && !exp_fault) begin
            for (int i = 0; i < bytes; i++) begin
                mem_model[int'(a) + i] = d[i*8 +: 8];
            end
        end
    endtask

    initial begin
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        int          pulses;
        int          pulse_cyc [2];
        logic [63:0] pulse_dat [2];

        reset    = 1'b1;
        memcycle = 1'b0;
        addr     = '0;
        width    = '0;
        wr       = 1'b0;
        wdata    = '0;
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 64'(ready), 64'd0);
        check("reset fault", 64'(fault), 64'd0);
        check("reset rdata", rdata, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Give every byte the model tracks a known value.
        for (int i = 0; i < 64; i++) begin
            do_req("fill", 1'b1, 2'd3, 64'(i * 8), {$urandom, $urandom}, 1'b0);
        end

        do_req("dword wr", 1'b1, 2'd3, 64'h100, 64'hDEADBEEF_CAFEF00D, 1'b0);
        do_req("dword rd", 1'b0, 2'd3, 64'h100, 64'd0, 1'b0);
        check("dword rd value", last_rdata, 64'hDEADBEEF_CAFEF00D);
        do_req("byte wr", 1'b1, 2'd0, 64'h103, 64'hAA, 1'b0);
        do_req("merge rd", 1'b0, 2'd3, 64'h100, 64'd0, 1'b0);
        check("merge rd value", last_rdata, 64'hDEADBEEF_AAFEF00D);
        do_req("half rd", 1'b0, 2'd1, 64'h106, 64'd0, 1'b0);
        check("half rd value", last_rdata, 64'h0000_0000_0000_DEAD);
        do_req("word rd", 1'b0, 2'd2, 64'h104, 64'd0, 1'b0);
        check("word rd value", last_rdata, 64'h0000_0000_DEAD_BEEF);
        do_req("misaligned rd", 1'b0, 2'd2, 64'h102, 64'd0, 1'b0);
        // 0x10000 would alias dword 0 if the range check were missing.
        do_req("oor wr", 1'b1, 2'd3, 64'h10000, 64'h0123_4567_89AB_CDEF, 1'b0);
        do_req("alias rd", 1'b0, 2'd3, 64'h0, 64'd0, 1'b0);

        // Reset while the byte write is in flight; the write must not land.
        do_req("pre-abort rd", 1'b0, 2'd3, 64'h100, 64'd0, 1'b0);
        @(negedge clk);
        addr     = 64'h100;
        width    = 2'd0;
        wr       = 1'b1;
        wdata    = 64'h55;
        memcycle = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        memcycle = 1'b0;
        #1;
        check("abort ready", 64'(ready), 64'd0);
        check("abort fault", 64'(fault), 64'd0);
        check("abort rdata", rdata, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        do_req("post-abort rd", 1'b0, 2'd3, 64'h100, 64'd0, 1'b0);
        check("post-abort value", last_rdata, 64'hDEADBEEF_AAFEF00D);

        // Back-to-back reads with memcycle held through DONE.
        exp_a  = model_read(64'h100, 8);
        exp_b  = model_read(64'h108, 8);
        pulses = 0;
        pulse_cyc = '{0, 0};
        pulse_dat = '{64'd0, 64'd0};
        @(negedge clk);
        addr     = 64'h100;
        width    = 2'd3;
        wr       = 1'b0;
        memcycle = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                if (pulses < 2) begin
                    pulse_cyc[pulses] = c;
                    pulse_dat[pulses] = rdata;
                end
                pulses++;
                if (pulses == 1) addr = 64'h108;
                else             memcycle = 1'b0;
            end
        end
        memcycle = 1'b0;
        check("b2b pulses", 64'(pulses), 64'd2);
        check("b2b first cycle", 64'(pulse_cyc[0]), 64'd2);
        check("b2b spacing", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'd3);
        check("b2b first data", pulse_dat[0], exp_a);
        check("b2b second data", pulse_dat[1], exp_b);

        // Randomized traffic: mostly legal accesses in the modelled window,
        // plus misaligned and out-of-range ones; the bus is scrambled after
        // acceptance to confirm requests are atomic.
        for (int n = 0; n < 300; n++) begin
            logic [1:0]  w;
            bit          is_wr;
            int          kind;
            logic [63:0] a;
            logic [63:0] align;
            w     = 2'($urandom_range(0, 3));
            is_wr = 1'($urandom_range(0, 1));
            kind  = $urandom_range(0, 9);
            align = ~64'((1 << w) - 1);
            case (kind)
                0:       a = 64'($urandom_range(0, 511));
                1:       a = (64'h10000 + 64'($urandom_range(0, 511))) & align;
                2:       a = {1'b1, 31'($urandom), 32'($urandom)} & align;
                default: a = 64'($urandom_range(0, 511)) & align;
            endcase
            do_req("random", is_wr, w, a, {$urandom, $urandom}, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the MMU's physical bus (addrout/width/memcycle).
- Services byte, half, word and dword reads and writes against an internal dword-organised RAM.
- Returns rdata with a one-cycle ready pulse, and flags misaligned or out-of-range accesses.
- Serves both CPU data cycles and page-structure walk fetches; it has no knowledge of which kind a request is.

Parameters:
- DEPTH, 8192: RAM size in 64-bit dwords; must be a power of 2. Valid byte addresses are 0 .. DEPTH*8-1.
- INIT_FILE, "": hex file loaded into the RAM at elaboration. Empty string means no preload.

Ports:
- clk  in  1  system clock; all state updates on the posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- addr  in  64  physical byte address.
- width  in  2  access size: 0=byte, 1=half, 2=word, 3=dword.
- memcycle  in  1  request valid; held high until ready.
- wr  in  1  1=write, 0=read; sampled with memcycle.
- wdata  in  64  write data, right-justified (the low 8/16/32/64 bits are used).
- rdata  out  64  read data, zero-extended, right-justified.
- ready  out  1  one-cycle completion pulse.
- fault  out  1  valid only with ready; 1 = access rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; ready=0, fault=0, rdata=0.
  - RAM contents are preserved.
  - Reset during any state aborts the access. A pending RMW write is never committed.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
- IDLE, memcycle=1: latch addr, width, wr and wdata. Then take the first matching case:
  - Misaligned (addr mod 2^width != 0) or addr >= DEPTH*8: go to DONE with fault=1 and no RAM access.
  - Read: go to RD. The RAM read of index addr[3+:log2(DEPTH)] is issued.
  - Write with width=3: go to WR.
  - Write with width<3: go to RMW_RD.
- RD: RAM data is valid. Extract the lane at byte offset addr[2:0], zero-extend it, register it into rdata, go to DONE.
- WR: write the full dword at the edge, go to DONE.
- RMW_RD: read the dword, merge wdata bytes into lanes addr[2:0] .. addr[2:0]+2^width-1, go to RMW_WR.
- RMW_WR: write the merged dword, go to DONE.
- DONE:
  - ready=1 for exactly this cycle. fault=1 only for rejected accesses.
  - rdata holds the read result, or 0 after a write or fault.
  - memcycle is ignored in DONE. Next state is IDLE, so a new request is accepted no earlier than the cycle after ready.
- Latency, from the edge that samples memcycle in IDLE to ready high:
  - Read: 2 cycles.
  - Dword write: 2 cycles.
  - Sub-dword write: 3 cycles.
  - Fault: 1 cycle.
- rdata is held stable until the next DONE. ready and fault are 0 in every state except DONE.
- Requests are atomic. Changes to addr, wdata, width or wr after acceptance in IDLE have no effect.
- memcycle dropped before ready: the access still completes, and ready still pulses.
- Read-after-write to the same address on back-to-back requests returns the new data. There is no bypass hazard, because RAM writes complete before DONE.

Optional Feature:
- MEMRESP_BYTE_EN_EN defined:
  - The RAM has 8 per-byte write enables.
  - Sub-dword writes go IDLE→WR→DONE with a 2-cycle latency.
  - RMW_RD and RMW_WR are unreachable and omitted.
- Undefined: sub-dword writes use the read-modify-write path above.
- Read and fault behaviour is identical in both builds.

Decomposition:
- mem_pkg holds:
  - typedef enum width_t {W_BYTE, W_HALF, W_WORD, W_DWORD}.
  - typedef enum state_t for the six states.
  - function lane_extract(dword, offset, width) returning the zero-extended lane.
  - function lane_merge(old, wdata, offset, width) returning the merged dword.
  - function byte_mask(offset, width) returning an 8-bit mask.
- Sub-module mem_ram: single-port synchronous RAM with parameters DEPTH and INIT_FILE, 1-cycle read latency, and an optional byte-enable port under the macro.

Test Plan:
- Dword path: write dword 0xDEADBEEF_CAFEF00D to addr 0x100, then read dword 0x100. Expect ready 2 cycles after each request, rdata=0xDEADBEEFCAFEF00D, fault=0.
- Byte write: after the above, byte write 0xAA to 0x103, then dword read 0x100. Expect rdata=0xDEADBEEF_AAFEF00D. Write latency is 3 cycles, or 2 with MEMRESP_BYTE_EN_EN.
- Lane extract: half read at 0x106. Expect rdata=0x000000000000DEAD. Word read at 0x104. Expect 0x00000000DEADBEEF.
- Faults:
  - Word read at 0x102 gives ready+fault 1 cycle after the request, with rdata=0.
  - Dword write at 0x10000 (DEPTH=8192) also faults, and RAM is unchanged.
- Reset abort: assert reset=0 asynchronously while in RMW_RD for a byte write of 0x55 to 0x100. Expect ready=0 and rdata=0 immediately. After release, dword read 0x100 returns the pre-write value.
- Back-to-back: hold memcycle high across DONE for consecutive reads of 0x100 then 0x108. Expect exactly two ready pulses, 3 cycles apart, with correct data each time.
